pll_speed_ctrl: RTL and testbench

Sequences the dynamic reconfiguration of the core's system PLL when the "Game Speed" OSD option (Native / 60Hz Adjust) changes. Synchronizes the asynchronous speed-select bit, issues the fixed three-write sequence (mode, fractional divider, start) to the PLL reconfiguration controller over its Avalon-MM management port, then waits for PLL lock with a timeout. It sits in the top-level `emu` between the `hps_io` status bus and `pll_cfg`, clocked by the PLL management clock.

---
 rtl/pll_speed_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pll_speed_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_speed_ctrl.sv
// Reprograms the system PLL fractional divider over Avalon-MM whenever the game-speed
// selection changes, then waits for PLL lock with a bounded timeout.

module pll_speed_ctrl #(
  parameter logic [31:0] FRAC_NATIVE  = 32'd3639383488,
  parameter logic [31:0] FRAC_ADJUST  = 32'd3268298314,
  parameter int unsigned LOCK_IGNORE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        speed_sel,
  input  logic        locked,
  input  logic        cfg_waitrequest,
  output logic        cfg_write,
  output logic [5:0]  cfg_address,
  output logic [31:0] cfg_data,
  output logic        busy,
  output logic        cur_speed,
  output logic        err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_MODE   = 3'd1;
  localparam logic [2:0] S_GAP1      = 3'd2;
  localparam logic [2:0] S_WR_FRAC   = 3'd3;
  localparam logic [2:0] S_GAP2      = 3'd4;
  localparam logic [2:0] S_WR_START  = 3'd5;
  localparam logic [2:0] S_SETTLE    = 3'd6;
  localparam logic [2:0] S_WAIT_LOCK = 3'd7;

  localparam logic [20:0] IGN_CNT = 21'(LOCK_IGNORE);
  localparam logic [20:0] TMO_CNT = 21'(LOCK_TIMEOUT);
  localparam logic [20:0] CNT_MAX = 21'h1F_FFFF;

  logic        spd_s1_q, spd_s2_q, lck_s1_q, lck_s2_q;
  logic        req_q, req_now_s, accept_s;
  logic [2:0]  state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic        cfg_write_q, cfg_write_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        cur_speed_q, cur_speed_d;
  logic        err_q, err_d;

  // Request needs a settled synchronizer pair that differs from the active speed;
  // it is registered once more so a new sequence starts after a full stable compare.
  assign req_now_s = (spd_s1_q == spd_s2_q) && (spd_s2_q != cur_speed_q);
  assign accept_s  = cfg_write_q && !cfg_waitrequest;

  // Sequencer next-state and registered-output next values
  always_comb begin
    state_d     = state_q;
    cfg_write_d = cfg_write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    busy_d      = busy_q;
    cur_speed_d = cur_speed_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_q && req_now_s) begin
          state_d     = S_WR_MODE;
          cur_speed_d = spd_s2_q;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          cfg_write_d = 1'b1;
          addr_d      = 6'd0;
          data_d      = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_MODE: begin
        if (accept_s) begin
          state_d     = S_GAP1;
          cfg_write_d = 1'b0;
        end else begin
          state_d = S_WR_MODE;
        end
      end
      S_GAP1: begin
        state_d     = S_WR_FRAC;
        cfg_write_d = 1'b1;
        addr_d      = 6'd7;
        data_d      = cur_speed_q ? FRAC_ADJUST : FRAC_NATIVE;
      end
      S_WR_FRAC: begin
        if (accept_s) begin
          state_d     = S_GAP2;
          cfg_write_d = 1'b0;
        end else begin
          state_d = S_WR_FRAC;
        end
      end
      S_GAP2: begin
        state_d     = S_WR_START;
        cfg_write_d = 1'b1;
        addr_d      = 6'd2;
        data_d      = 32'd0;
      end
      S_WR_START: begin
        if (accept_s) begin
          state_d     = S_SETTLE;
          cfg_write_d = 1'b0;
        end else begin
          state_d = S_WR_START;
        end
      end
      S_SETTLE: begin
        if (cnt_q >= IGN_CNT) begin
          state_d = S_WAIT_LOCK;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_WAIT_LOCK: begin
        if (lck_s2_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q >= TMO_CNT) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT_LOCK;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cfg_write_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Saturating cycle counter, restarted on every state change
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = 21'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 21'd1;
    end
  end

  // State, synchronizers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spd_s1_q    <= 1'b0;
      spd_s2_q    <= 1'b0;
      lck_s1_q    <= 1'b0;
      lck_s2_q    <= 1'b0;
      req_q       <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 21'd0;
      cfg_write_q <= 1'b0;
      addr_q      <= 6'd0;
      data_q      <= 32'd0;
      busy_q      <= 1'b0;
      cur_speed_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      spd_s1_q    <= speed_sel;
      spd_s2_q    <= spd_s1_q;
      lck_s1_q    <= locked;
      lck_s2_q    <= lck_s1_q;
      req_q       <= req_now_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_write_q <= cfg_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      cur_speed_q <= cur_speed_d;
      err_q       <= err_d;
    end
  end

  assign cfg_write   = cfg_write_q;
  assign cfg_address = addr_q;
  assign cfg_data    = data_q;
  assign busy        = busy_q;
  assign cur_speed   = cur_speed_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pll_speed_ctrl.sv
// Directed bench for pll_speed_ctrl: write sequence timing, waitrequest stretch,
// back-to-back requests, lock timeout and asynchronous reset mid-sequence.

module tb_pll_speed_ctrl;

  localparam logic [31:0] NATIVE = 32'd3639383488;
  localparam logic [31:0] ADJUST = 32'd3268298314;

  logic        clk, reset, speed_sel, locked, cfg_waitrequest;
  logic        cfg_write, busy, cur_speed, err;
  logic [5:0]  cfg_address;
  logic [31:0] cfg_data;
  int          compared, mismatched;

  pll_speed_ctrl #(.LOCK_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .speed_sel(speed_sel), .locked(locked),
    .cfg_waitrequest(cfg_waitrequest), .cfg_write(cfg_write),
    .cfg_address(cfg_address), .cfg_data(cfg_data),
    .busy(busy), .cur_speed(cur_speed), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; speed_sel = 1'b0; locked = 1'b1; cfg_waitrequest = 1'b0;
    repeat (3) tick();
    compared++;
    if ({cfg_write, cfg_address, cfg_data, busy, cur_speed, err} !== 42'd0) begin
      mismatched++;
      $display("FAIL reset_values: got wr=%b a=%0d d=%h busy=%b cur=%b err=%b, expected all 0",
               cfg_write, cfg_address, cfg_data, busy, cur_speed, err);
    end
    reset = 1'b0;
    for (int d = 1; d <= 1000; d++) begin
      tick();
      compared++;
      if ({cfg_write, busy, cur_speed, err} !== 4'b0000) begin
        mismatched++;
        $display("FAIL idle_quiet cyc %0d: got wr/busy/cur/err=%b, expected 0000", d,
                 {cfg_write, busy, cur_speed, err});
      end
    end
  endtask

  task automatic test_basic_switch();
    logic exp_wr, exp_busy;
    logic [5:0] exp_a;
    logic [31:0] exp_d;
    speed_sel = 1'b1; locked = 1'b0;
    for (int d = 1; d <= 40; d++) begin
      tick();
      exp_wr   = (d == 4) || (d == 6) || (d == 8);
      exp_busy = (d >= 4) && (d < 33);
      exp_a    = (d == 4) ? 6'd0 : ((d == 6) ? 6'd7 : 6'd2);
      exp_d    = (d == 6) ? ADJUST : 32'd0;
      compared++;
      if (cfg_write !== exp_wr) begin
        mismatched++;
        $display("FAIL basic_write cyc %0d: got %b expected %b", d, cfg_write, exp_wr);
      end
      compared++;
      if (busy !== exp_busy) begin
        mismatched++;
        $display("FAIL basic_busy cyc %0d: got %b expected %b", d, busy, exp_busy);
      end
      if (exp_wr) begin
        compared++;
        if (cfg_address !== exp_a || cfg_data !== exp_d) begin
          mismatched++;
          $display("FAIL basic_addr_data cyc %0d: got %0d/%0d expected %0d/%0d", d,
                   cfg_address, cfg_data, exp_a, exp_d);
        end
      end
      if (d == 30) locked = 1'b1;
    end
    compared++;
    if (cur_speed !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_final: got cur=%b err=%b expected cur=1 err=0", cur_speed, err);
    end
  endtask

  task automatic test_waitrequest_stretch();
    logic exp_wr, exp_busy;
    logic [5:0] exp_a;
    logic [31:0] exp_d;
    speed_sel = 1'b0;
    for (int d = 1; d <= 36; d++) begin
      tick();
      exp_wr   = (d == 4) || ((d >= 6) && (d <= 11)) || (d == 13);
      exp_busy = (d >= 4) && (d < 32);
      exp_a    = (d == 4) ? 6'd0 : ((d == 13) ? 6'd2 : 6'd7);
      exp_d    = ((d >= 6) && (d <= 11)) ? NATIVE : 32'd0;
      compared++;
      if (cfg_write !== exp_wr) begin
        mismatched++;
        $display("FAIL wreq_write cyc %0d: got %b expected %b", d, cfg_write, exp_wr);
      end
      compared++;
      if (busy !== exp_busy) begin
        mismatched++;
        $display("FAIL wreq_busy cyc %0d: got %b expected %b", d, busy, exp_busy);
      end
      if (exp_wr) begin
        compared++;
        if (cfg_address !== exp_a || cfg_data !== exp_d) begin
          mismatched++;
          $display("FAIL wreq_addr_data cyc %0d: got %0d/%0d expected %0d/%0d", d,
                   cfg_address, cfg_data, exp_a, exp_d);
        end
      end
      cfg_waitrequest = (d >= 6) && (d <= 10);
    end
    compared++;
    if (cur_speed !== 1'b0) begin
      mismatched++;
      $display("FAIL wreq_cur_speed: got %b expected 0", cur_speed);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_wr, exp_busy, exp_cur;
    logic [31:0] exp_d;
    speed_sel = 1'b1; locked = 1'b1; cfg_waitrequest = 1'b0;
    for (int d = 1; d <= 55; d++) begin
      tick();
      exp_wr   = (d == 4) || (d == 6) || (d == 8) || (d == 28) || (d == 30) || (d == 32);
      exp_busy = ((d >= 4) && (d < 27)) || ((d >= 28) && (d < 51));
      exp_cur  = (d >= 4) && (d < 28);
      exp_d    = (d == 6) ? ADJUST : ((d == 30) ? NATIVE : 32'd0);
      compared++;
      if (cfg_write !== exp_wr) begin
        mismatched++;
        $display("FAIL b2b_write cyc %0d: got %b expected %b", d, cfg_write, exp_wr);
      end
      compared++;
      if (busy !== exp_busy || cur_speed !== exp_cur) begin
        mismatched++;
        $display("FAIL b2b_busy_cur cyc %0d: got %b/%b expected %b/%b", d, busy, cur_speed,
                 exp_busy, exp_cur);
      end
      if (exp_wr) begin
        compared++;
        if (cfg_data !== exp_d) begin
          mismatched++;
          $display("FAIL b2b_data cyc %0d: got %0d expected %0d", d, cfg_data, exp_d);
        end
      end
      if (d == 6) speed_sel = 1'b0;
    end
  endtask

  task automatic test_lock_timeout();
    logic exp_busy, exp_err;
    speed_sel = 1'b1; locked = 1'b0;
    for (int d = 1; d <= 95; d++) begin
      tick();
      exp_busy = (d >= 4) && (d < 91);
      exp_err  = (d >= 91);
      compared++;
      if (busy !== exp_busy || err !== exp_err) begin
        mismatched++;
        $display("FAIL timeout cyc %0d: got busy/err %b/%b expected %b/%b", d, busy, err,
                 exp_busy, exp_err);
      end
    end
    speed_sel = 1'b0; locked = 1'b1;
    for (int d = 1; d <= 30; d++) begin
      tick();
      exp_busy = (d >= 4) && (d < 27);
      exp_err  = (d < 4);
      compared++;
      if (busy !== exp_busy || err !== exp_err || cur_speed !== (d < 4)) begin
        mismatched++;
        $display("FAIL err_clear cyc %0d: got busy/err/cur %b/%b/%b expected %b/%b/%b", d,
                 busy, err, cur_speed, exp_busy, exp_err, (d < 4));
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic exp_wr, exp_busy;
    logic [31:0] exp_d;
    speed_sel = 1'b1;
    for (int d = 1; d <= 10; d++) begin
      tick();
      exp_wr = (d == 4) || (d == 6) || (d >= 8);
      compared++;
      if (cfg_write !== exp_wr) begin
        mismatched++;
        $display("FAIL pre_reset_write cyc %0d: got %b expected %b", d, cfg_write, exp_wr);
      end
      if (d == 7) cfg_waitrequest = 1'b1;
    end
    compared++;
    if (cfg_address !== 6'd2) begin
      mismatched++;
      $display("FAIL pre_reset_addr: got %0d expected 2", cfg_address);
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({cfg_write, cfg_address, cfg_data, busy, cur_speed, err} !== 42'd0) begin
      mismatched++;
      $display("FAIL async_reset: got wr=%b a=%0d d=%h busy=%b cur=%b err=%b, expected all 0",
               cfg_write, cfg_address, cfg_data, busy, cur_speed, err);
    end
    repeat (3) tick();
    compared++;
    if ({cfg_write, busy, cur_speed} !== 3'b000) begin
      mismatched++;
      $display("FAIL held_reset: got wr/busy/cur %b expected 000", {cfg_write, busy, cur_speed});
    end
    reset = 1'b0; cfg_waitrequest = 1'b0;
    for (int d = 1; d <= 30; d++) begin
      tick();
      exp_wr   = (d == 4) || (d == 6) || (d == 8);
      exp_busy = (d >= 4) && (d < 27);
      exp_d    = (d == 6) ? ADJUST : 32'd0;
      compared++;
      if (cfg_write !== exp_wr || busy !== exp_busy) begin
        mismatched++;
        $display("FAIL post_reset cyc %0d: got wr/busy %b/%b expected %b/%b", d, cfg_write,
                 busy, exp_wr, exp_busy);
      end
      if (exp_wr) begin
        compared++;
        if (cfg_data !== exp_d) begin
          mismatched++;
          $display("FAIL post_reset_data cyc %0d: got %0d expected %0d", d, cfg_data, exp_d);
        end
      end
    end
    compared++;
    if (cur_speed !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_cur: got %b expected 1", cur_speed);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_basic_switch();
    test_waitrequest_stretch();
    test_back_to_back();
    test_lock_timeout();
    test_reset_mid_sequence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
